// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
// Round-robin arbiter that lets NUM_CH requesters share one synchronous RAM
// port with multi-beat read/write bursts (one beat per cycle).
//
// State table:
//   state | meaning
//   IDLE  | no burst owner; arbitrate among req_in, grant takes effect next edge
//   BURST | issuing beats of the latched burst, one address per cycle
//   DRAIN | read burst fully issued; waiting for the last RAM_LAT returns
//
// Ports:
//   clk_in, rst_n_in            clock, async active-low reset
//   req_in/we_in/addr_in/len_in per-channel burst request and fields
//   wdata_in                    per-channel current write beat
//   gnt_out                     one-hot burst owner
//   wack_out                    write beat consumed this cycle
//   rvalid_out/rdata_out        read beat return
//   done_out                    pulse with the final beat of a burst
//   mem_*                       RAM port (read data arrives RAM_LAT later)
module mem_burst_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int STRIDE     = 4,
  parameter int RAM_LAT    = 1
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [NUM_CH-1:0]            req_in,
  input  logic [NUM_CH-1:0]            we_in,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  len_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata_in,
  output logic [NUM_CH-1:0]            gnt_out,
  output logic [NUM_CH-1:0]            wack_out,
  output logic [NUM_CH-1:0]            rvalid_out,
  output logic [DATA_WIDTH-1:0]        rdata_out,
  output logic [NUM_CH-1:0]            done_out,
  output logic [ADDR_WIDTH-1:0]        mem_addr_out,
  output logic                         mem_we_out,
  output logic [DATA_WIDTH-1:0]        mem_wdata_out,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_in
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      owner_q, last_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  beats_q;     // beats remaining after the current one
  logic [RAM_LAT-1:0]    v_pipe, l_pipe;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_CH-1:0]     owner_oh;
  logic                  in_burst, last_beat, rd_beat, wr_done, rd_done;
  int                    c;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    c          = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(last_q) + i) % NUM_CH;
      if (!pick_valid && req_in[c]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(c);
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign last_beat = in_burst && (beats_q == '0);
  assign rd_beat   = in_burst && !we_q;
  assign wr_done   = last_beat && we_q;
  // The oldest pipe stage lines up with mem_rdata_in for the beat it tracks.
  assign rd_done   = v_pipe[RAM_LAT-1] && l_pipe[RAM_LAT-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    owner_oh      = {{(NUM_CH-1){1'b0}}, 1'b1} << owner_q;
    gnt_out       = '0;
    wack_out      = '0;
    rvalid_out    = '0;
    rdata_out     = '0;
    done_out      = '0;
    mem_addr_out  = '0;
    mem_we_out    = 1'b0;
    mem_wdata_out = '0;

    case (state_q)
      IDLE:  if (pick_valid) state_d = BURST;
      BURST: if (last_beat) state_d = we_q ? IDLE : DRAIN;
      DRAIN: if (rd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) gnt_out = owner_oh;
    if (in_burst) begin
      mem_addr_out = addr_q;
      if (we_q) begin
        mem_we_out    = 1'b1;
        mem_wdata_out = wdata_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        wack_out      = owner_oh;
      end
    end
    if (v_pipe[RAM_LAT-1]) begin
      rvalid_out = owner_oh;
      rdata_out  = mem_rdata_in;
    end
    if (wr_done || rd_done) done_out = owner_oh;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_CH-1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      beats_q <= '0;
    end else if (state_q == IDLE) begin
      if (pick_valid) begin
        owner_q <= pick_idx;
        last_q  <= pick_idx;
        we_q    <= we_in[pick_idx];
        addr_q  <= addr_in[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        beats_q <= len_in[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
      end
    end else if (in_burst) begin
      addr_q <= addr_q + ADDR_WIDTH'(STRIDE);
      if (beats_q != '0) beats_q <= beats_q - 1'b1;
    end
  end

  // Tracks in-flight read beats; cleared by reset so stale returns are dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe[0] <= rd_beat;
      l_pipe[0] <= rd_beat && last_beat;
      for (int i = 1; i < RAM_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
    end
  end

endmodule
